// File: rtl/gray_code_counter_pkg.sv
// gray_pkg: shared width default and binary/Gray conversion helpers
package gray_pkg;
  localparam int GRAY_WIDTH = 4;
  function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
    logic [GRAY_WIDTH-1:0] b;
    b[GRAY_WIDTH-1] = g[GRAY_WIDTH-1];
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_code_counter_if.sv
// gray_code_counter_if: counter bus; master drives en/up/load/G_in, slave returns B/G/wrap
interface gray_code_counter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) ();
  logic en;
  logic up;
  logic load;
  logic [WIDTH-1:0] G_in;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] G;
  logic wrap;
  modport master (output en, up, load, G_in, input B, G, wrap);
  modport slave (input en, up, load, G_in, output B, G, wrap);
endinterface

// File: rtl/gray_code_counter_gray_to_bin.sv
// gray_to_bin: combinational Gray decoder (g in, b out), bit i is the XOR of g[WIDTH-1:i]
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down counter with registered B, G and wrap (ports clk, rst, io slave: en, up, load, G_in -> B, G, wrap)
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic clk,
  input  logic rst,
  gray_code_counter_if.slave io
);
  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] step_b;
  logic wrap_n;
  gray_to_bin #(.WIDTH(WIDTH)) u_dec (.g(io.G_in), .b(load_b));
  always_comb begin
    step_b = io.up ? io.B + WIDTH'(1) : io.B - WIDTH'(1);
    wrap_n = io.up ? &io.B : ~|io.B;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      io.B <= '0;
      io.G <= '0;
      io.wrap <= 1'b0;
    end else if (io.load) begin
      io.B <= load_b;
      io.G <= io.G_in;
      io.wrap <= 1'b0;
    end else if (io.en) begin
      io.B <= step_b;
      io.G <= step_b ^ (step_b >> 1);
      io.wrap <= wrap_n;
    end else begin
      io.wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed self-checking bench for gray_code_counter
module tb_gray_code_counter;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] prev_g;
  logic [3:0] up_g [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  always #5 clk = ~clk;
  gray_code_counter_if #(.WIDTH(4)) io ();
  gray_code_counter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .io(io.slave));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
    check({tag, ".B"}, 32'(io.B), 32'(b));
    check({tag, ".G"}, 32'(io.G), 32'(g));
    check({tag, ".wrap"}, 32'(io.wrap), 32'(w));
  endtask
  initial begin
    rst = 1'b1;
    io.en = 1'b1;
    io.up = 1'b1;
    io.load = 1'b1;
    io.G_in = 4'b1101;
    step();
    step();
    expect_out("reset", 4'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    io.en = 1'b0;
    io.load = 1'b0;
    step();
    expect_out("post_reset_hold", 4'd0, 4'b0000, 1'b0);
    io.en = 1'b1;
    io.up = 1'b1;
    prev_g = io.G;
    for (int i = 0; i < 16; i++) begin
      step();
      expect_out($sformatf("up%0d", i), 4'(i + 1), up_g[i], i == 15);
      check($sformatf("up%0d.onebit", i), 32'($countones(io.G ^ prev_g)), 32'd1);
      prev_g = io.G;
    end
    io.up = 1'b0;
    step();
    expect_out("down_wrap", 4'd15, 4'b1000, 1'b1);
    step();
    expect_out("down_next", 4'd14, 4'b1001, 1'b0);
    io.load = 1'b1;
    io.G_in = 4'b1101;
    step();
    expect_out("load_1101", 4'd9, 4'b1101, 1'b0);
    io.load = 1'b0;
    io.up = 1'b1;
    step();
    expect_out("load_then_up", 4'd10, 4'b1111, 1'b0);
    io.load = 1'b1;
    io.G_in = 4'b1000;
    step();
    expect_out("load_1000", 4'd15, 4'b1000, 1'b0);
    io.G_in = 4'b0000;
    step();
    expect_out("load_0000", 4'd0, 4'b0000, 1'b0);
    io.G_in = 4'b0101;
    step();
    expect_out("load_6", 4'd6, 4'b0101, 1'b0);
    io.load = 1'b0;
    io.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("hold%0d", i), 4'd6, 4'b0101, 1'b0);
    end
    rst = 1'b1;
    io.load = 1'b1;
    io.G_in = 4'b1101;
    step();
    expect_out("rst_over_load", 4'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    io.G_in = 4'b0010;
    step();
    expect_out("load_3", 4'd3, 4'b0010, 1'b0);
    io.load = 1'b0;
    io.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io.up = (i % 2 == 0);
      step();
      expect_out($sformatf("toggle%0d", i), (i % 2 == 0) ? 4'd4 : 4'd3,
                 (i % 2 == 0) ? 4'b0110 : 4'b0010, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
